pipe_stage_reg: RTL and testbench

PIPE_STAGE_REG -- requirements
Module: pipe_stage_reg

---
 rtl/pipe_pkg.sv | 15 +
 rtl/pipe_stage_reg_if.sv | 29 ++
 rtl/pipe_entry.sv | 33 +++
 rtl/pipe_stage_reg.sv | 73 +++++++
 tb/tb_pipe_stage_reg.sv | 232 +++++++++++++++++++++++
 5 files changed

// File: rtl/pipe_pkg.sv
// pipe_pkg: default widths and control-bit positions shared by pipeline stage registers
package pipe_pkg;
  localparam int DEF_DATA_W = 16;
  localparam int DEF_CTRL_W = 9;
  localparam int DEF_RD_W = 4;
  localparam int REGDST = 0;
  localparam int BRANCH = 1;
  localparam int MEMTOREG = 2;
  localparam int ALUSRC = 3;
  localparam int REGWRITE = 4;
  localparam int BRANCHREG = 5;
  localparam int PCS = 6;
  localparam int HLT = 7;
  localparam int LB = 8;
endpackage

// File: rtl/pipe_stage_reg_if.sv
// pipe_stage_reg_if: valid/ready upstream and downstream bundle of a pipeline stage register
interface pipe_stage_reg_if
  import pipe_pkg::*;
#(
  parameter int DATA_W = DEF_DATA_W,
  parameter int CTRL_W = DEF_CTRL_W,
  parameter int RD_W = DEF_RD_W
);
  logic in_valid;
  logic in_ready;
  logic [CTRL_W-1:0] in_ctrl;
  logic [RD_W-1:0] in_rd;
  logic [DATA_W-1:0] in_data;
  logic flush;
  logic out_valid;
  logic out_ready;
  logic [CTRL_W-1:0] out_ctrl;
  logic [RD_W-1:0] out_rd;
  logic [DATA_W-1:0] out_data;
  logic [1:0] occupancy;
  modport master (
    output in_valid, in_ctrl, in_rd, in_data, flush, out_ready,
    input in_ready, out_valid, out_ctrl, out_rd, out_data, occupancy
  );
  modport slave (
    input in_valid, in_ctrl, in_rd, in_data, flush, out_ready,
    output in_ready, out_valid, out_ctrl, out_rd, out_data, occupancy
  );
endinterface

// File: rtl/pipe_entry.sv
// pipe_entry: one valid+ctrl+rd+data slot; fields are forced to zero whenever the slot is empty
module pipe_entry #(
  parameter int DATA_W = 16,
  parameter int CTRL_W = 9,
  parameter int RD_W = 4
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              load,
  input  logic              clr,
  input  logic              d_valid,
  input  logic [CTRL_W-1:0] d_ctrl,
  input  logic [RD_W-1:0]   d_rd,
  input  logic [DATA_W-1:0] d_data,
  output logic              valid,
  output logic [CTRL_W-1:0] ctrl,
  output logic [RD_W-1:0]   rd,
  output logic [DATA_W-1:0] data
);
  always_ff @(posedge clk) begin
    if (rst || clr) begin
      valid <= 1'b0;
      ctrl <= '0;
      rd <= '0;
      data <= '0;
    end else if (load) begin
      valid <= d_valid;
      ctrl <= d_valid ? d_ctrl : '0;
      rd <= d_valid ? d_rd : '0;
      data <= d_valid ? d_data : '0;
    end
  end
endmodule

// File: rtl/pipe_stage_reg.sv
// pipe_stage_reg: flushable valid/ready pipeline register; PIPE_STAGE_SKID_EN adds a skid entry and registered in_ready
module pipe_stage_reg
  import pipe_pkg::*;
#(
  parameter int DATA_W = DEF_DATA_W,
  parameter int CTRL_W = DEF_CTRL_W,
  parameter int RD_W = DEF_RD_W
) (
  input logic clk,
  input logic rst,
  pipe_stage_reg_if.slave bus
);
  logic accept, rel, head_valid, head_load, hd_valid;
  logic [CTRL_W-1:0] hd_ctrl;
  logic [RD_W-1:0] hd_rd;
  logic [DATA_W-1:0] hd_data;
  assign accept = bus.in_valid && bus.in_ready;
  assign rel = head_valid && bus.out_ready;
  assign head_load = !head_valid || rel;
  assign bus.out_valid = head_valid;
`ifdef PIPE_STAGE_SKID_EN
  logic skid_valid;
  logic [CTRL_W-1:0] skid_ctrl;
  logic [RD_W-1:0] skid_rd;
  logic [DATA_W-1:0] skid_data;
  assign bus.in_ready = !skid_valid && !rst;
  assign bus.occupancy = 2'(head_valid) + 2'(skid_valid);
  // a held skid entry always refills the head before any new input
  always_comb begin
    hd_valid = skid_valid || accept;
    hd_ctrl = skid_valid ? skid_ctrl : bus.in_ctrl;
    hd_rd = skid_valid ? skid_rd : bus.in_rd;
    hd_data = skid_valid ? skid_data : bus.in_data;
  end
  pipe_entry #(.DATA_W(DATA_W), .CTRL_W(CTRL_W), .RD_W(RD_W)) u_skid (
    .clk(clk),
    .rst(rst),
    .load(accept && head_valid && !rel),
    .clr(bus.flush || rel),
    .d_valid(1'b1),
    .d_ctrl(bus.in_ctrl),
    .d_rd(bus.in_rd),
    .d_data(bus.in_data),
    .valid(skid_valid),
    .ctrl(skid_ctrl),
    .rd(skid_rd),
    .data(skid_data)
  );
`else
  assign bus.in_ready = !rst && (!head_valid || bus.out_ready);
  assign bus.occupancy = {1'b0, head_valid};
  always_comb begin
    hd_valid = accept;
    hd_ctrl = bus.in_ctrl;
    hd_rd = bus.in_rd;
    hd_data = bus.in_data;
  end
`endif
  pipe_entry #(.DATA_W(DATA_W), .CTRL_W(CTRL_W), .RD_W(RD_W)) u_head (
    .clk(clk),
    .rst(rst),
    .load(head_load),
    .clr(bus.flush),
    .d_valid(hd_valid),
    .d_ctrl(hd_ctrl),
    .d_rd(hd_rd),
    .d_data(hd_data),
    .valid(head_valid),
    .ctrl(bus.out_ctrl),
    .rd(bus.out_rd),
    .data(bus.out_data)
  );
endmodule

// File: tb/tb_pipe_stage_reg.sv
// tb_pipe_stage_reg: directed and randomized checks of pipe_stage_reg against a queue model
module tb_pipe_stage_reg;
  localparam int DW = 16;
  localparam int CW = 9;
  localparam int RW = 4;
`ifdef PIPE_STAGE_SKID_EN
  localparam int DEPTH = 2;
`else
  localparam int DEPTH = 1;
`endif
  typedef struct packed {
    logic [CW-1:0] c;
    logic [RW-1:0] r;
    logic [DW-1:0] d;
  } item_t;
  logic clk = 1'b0;
  logic rst;
  int checks = 0;
  int errors = 0;
  pipe_stage_reg_if #(.DATA_W(DW), .CTRL_W(CW), .RD_W(RW)) bus ();
  pipe_stage_reg #(.DATA_W(DW), .CTRL_W(CW), .RD_W(RW)) dut (
    .clk(clk),
    .rst(rst),
    .bus(bus.slave)
  );
  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    @(negedge clk);
  endtask

  task automatic idle();
    bus.in_valid = 1'b0;
    bus.in_ctrl = '0;
    bus.in_rd = '0;
    bus.in_data = '0;
    bus.flush = 1'b0;
    bus.out_ready = 1'b0;
  endtask

  task automatic test_reset();
    idle();
    rst = 1'b1;
    bus.in_valid = 1'b1;
    bus.in_data = 16'hbeef;
    bus.in_ctrl = 9'h1ff;
    tick();
    tick();
    #1;
    checks++;
    if (bus.in_ready !== 1'b0) begin errors++; $display("FAIL reset_in_ready: got %b exp 0", bus.in_ready); end
    checks++;
    if ({bus.out_valid, bus.out_ctrl, bus.out_rd, bus.out_data, bus.occupancy} !== '0) begin
      errors++; $display("FAIL reset_outs: v=%b c=%h r=%h d=%h occ=%0d exp all 0", bus.out_valid, bus.out_ctrl, bus.out_rd, bus.out_data, bus.occupancy);
    end
    idle();
    rst = 1'b0;
    #1;
    checks++;
    if (bus.in_ready !== 1'b1) begin errors++; $display("FAIL reset_release_ready: got %b exp 1", bus.in_ready); end
    tick();
  endtask

  task automatic test_single_pass();
    idle();
    bus.in_valid = 1'b1;
    bus.in_data = 16'h1234;
    bus.in_ctrl = 9'h011;
    bus.in_rd = 4'h5;
    bus.out_ready = 1'b1;
    #1;
    checks++;
    if (bus.out_valid !== 1'b0) begin errors++; $display("FAIL single_comb_path: out_valid got %b exp 0", bus.out_valid); end
    tick();
    bus.in_valid = 1'b0;
    #1;
    checks++;
    if (bus.out_valid !== 1'b1 || bus.out_data !== 16'h1234 || bus.out_ctrl !== 9'h011 || bus.out_rd !== 4'h5 || bus.occupancy !== 2'd1) begin
      errors++; $display("FAIL single_pass: v=%b d=%h c=%h r=%h occ=%0d exp 1 1234 011 5 1", bus.out_valid, bus.out_data, bus.out_ctrl, bus.out_rd, bus.occupancy);
    end
    tick();
    checks++;
    if (bus.out_valid !== 1'b0 || bus.out_data !== '0 || bus.occupancy !== 2'd0) begin
      errors++; $display("FAIL single_drain: v=%b d=%h occ=%0d exp 0 0 0", bus.out_valid, bus.out_data, bus.occupancy);
    end
  endtask

  task automatic test_stall();
    idle();
    bus.in_valid = 1'b1;
    bus.in_data = 16'h0001;
    tick();
    bus.in_data = 16'h0002;
    #1;
    checks++;
    if (bus.in_ready !== (DEPTH == 2)) begin errors++; $display("FAIL stall_ready_one: got %b exp %b", bus.in_ready, DEPTH == 2); end
    tick();
    bus.in_data = 16'h0003;
    #1;
    checks++;
    if (bus.occupancy !== 2'(DEPTH) || bus.in_ready !== 1'b0 || bus.out_data !== 16'h0001) begin
      errors++; $display("FAIL stall_full: occ=%0d rdy=%b d=%h exp %0d 0 0001", bus.occupancy, bus.in_ready, bus.out_data, DEPTH);
    end
    bus.in_valid = 1'b0;
    bus.out_ready = 1'b1;
    tick();
    #1;
    checks++;
    if (DEPTH == 2 ? (bus.out_valid !== 1'b1 || bus.out_data !== 16'h0002) : (bus.out_valid !== 1'b0 || bus.out_data !== '0)) begin
      errors++; $display("FAIL stall_second: v=%b d=%h", bus.out_valid, bus.out_data);
    end
    tick();
    checks++;
    if (bus.out_valid !== 1'b0 || bus.occupancy !== 2'd0) begin errors++; $display("FAIL stall_empty: v=%b occ=%0d exp 0 0", bus.out_valid, bus.occupancy); end
  endtask

  task automatic test_flush();
    idle();
    for (int i = 0; i < DEPTH; i++) begin
      bus.in_valid = 1'b1;
      bus.in_data = 16'(16'h0a00 + i);
      bus.in_ctrl = 9'h010;
      tick();
    end
    #1;
    checks++;
    if (bus.occupancy !== 2'(DEPTH)) begin errors++; $display("FAIL flush_fill: occ=%0d exp %0d", bus.occupancy, DEPTH); end
    bus.flush = 1'b1;
    bus.out_ready = 1'b1;
    bus.in_data = 16'hcccc;
    tick();
    bus.flush = 1'b0;
    bus.in_valid = 1'b0;
    #1;
    checks++;
    if (bus.out_valid !== 1'b0 || bus.out_ctrl !== '0 || bus.out_data !== '0 || bus.occupancy !== 2'd0) begin
      errors++; $display("FAIL flush: v=%b c=%h d=%h occ=%0d exp 0 0 0 0", bus.out_valid, bus.out_ctrl, bus.out_data, bus.occupancy);
    end
    for (int i = 0; i < 3; i++) begin
      tick();
      checks++;
      if (bus.out_valid !== 1'b0) begin errors++; $display("FAIL flush_ghost: out_valid=%b d=%h exp 0", bus.out_valid, bus.out_data); end
    end
  endtask

  task automatic test_reset_mid_stall();
    idle();
    bus.in_valid = 1'b1;
    bus.in_data = 16'h5a5a;
    bus.in_rd = 4'h9;
    tick();
    bus.in_valid = 1'b0;
    #1;
    checks++;
    if (bus.occupancy !== 2'd1) begin errors++; $display("FAIL rms_hold: occ=%0d exp 1", bus.occupancy); end
    rst = 1'b1;
    tick();
    rst = 1'b0;
    #1;
    checks++;
    if ({bus.out_valid, bus.out_ctrl, bus.out_rd, bus.out_data, bus.occupancy} !== '0 || bus.in_ready !== 1'b1) begin
      errors++; $display("FAIL rms_after: v=%b c=%h r=%h d=%h occ=%0d rdy=%b exp zeros rdy=1", bus.out_valid, bus.out_ctrl, bus.out_rd, bus.out_data, bus.occupancy, bus.in_ready);
    end
  endtask

  task automatic test_random();
    item_t mq[$];
    item_t sent_q[$];
    item_t got_q[$];
    item_t exp_h, nw;
    logic exp_rdy, acc, rel;
    int cyc = 0;
    idle();
    while (sent_q.size() < 1000 && cyc < 20000) begin
      nw = item_t'({$urandom, $urandom});
      bus.in_valid = $urandom_range(0, 3) != 0;
      bus.in_ctrl = nw.c;
      bus.in_rd = nw.r;
      bus.in_data = nw.d;
      bus.out_ready = $urandom_range(0, 2) != 0;
      #1;
      exp_rdy = DEPTH == 2 ? mq.size() < 2 : (mq.size() == 0 || bus.out_ready);
      exp_h = mq.size() != 0 ? mq[0] : '0;
      checks++;
      if (bus.in_ready !== exp_rdy) begin errors++; $display("FAIL rand_ready cyc %0d: got %b exp %b", cyc, bus.in_ready, exp_rdy); end
      checks++;
      if (bus.out_valid !== (mq.size() != 0) || bus.occupancy !== 2'(mq.size()) || {bus.out_ctrl, bus.out_rd, bus.out_data} !== exp_h) begin
        errors++; $display("FAIL rand_out cyc %0d: v=%b occ=%0d f=%h exp v=%b occ=%0d f=%h", cyc, bus.out_valid, bus.occupancy, {bus.out_ctrl, bus.out_rd, bus.out_data}, mq.size() != 0, mq.size(), exp_h);
      end
      acc = bus.in_valid && exp_rdy;
      rel = mq.size() != 0 && bus.out_ready;
      if (rel) begin
        got_q.push_back({bus.out_ctrl, bus.out_rd, bus.out_data});
        void'(mq.pop_front());
      end
      if (acc) begin
        mq.push_back(nw);
        sent_q.push_back(nw);
      end
      tick();
      cyc++;
    end
    bus.in_valid = 1'b0;
    bus.out_ready = 1'b1;
    for (int i = 0; i < 4 && mq.size() != 0; i++) begin
      #1;
      if (bus.out_valid === 1'b1) got_q.push_back({bus.out_ctrl, bus.out_rd, bus.out_data});
      void'(mq.pop_front());
      tick();
    end
    checks++;
    if (sent_q.size() != 1000 || got_q.size() != sent_q.size()) begin
      errors++; $display("FAIL rand_count: sent %0d got %0d exp 1000 each", sent_q.size(), got_q.size());
    end
    for (int i = 0; i < got_q.size() && i < sent_q.size(); i++) begin
      checks++;
      if (got_q[i] !== sent_q[i]) begin errors++; $display("FAIL rand_order idx %0d: got %h exp %h", i, got_q[i], sent_q[i]); end
    end
  endtask

  initial begin
    test_reset();
    test_single_pass();
    test_stall();
    test_flush();
    test_reset_mid_stall();
    test_random();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
